nway_sa_cache: RTL
==================

Name: nway_sa_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement. It is the generalised successor to the fixed 4-way sa_cache. It sits between a single-issue requester (CPU/LSU side) and a line-wide memory port with a valid/ack handshake. Ways, sets, word width and line length are all configurable.

Parameters:
WAYS, 4, associativity; power of two, >=2
SETS, 16, sets per way; power of two, >=2
ADDR_W, 32, word-address width
WORD_W, 32, data word width
LINE_WORDS, 4, words per line; power of two, >=2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
i_req_valid  input  1  request present
i_req_we  input  1  1 = write, 0 = read
i_addr  input  ADDR_W  word address
i_wdata  input  WORD_W  write data
o_req_ready  output  1  request accepted when valid and ready
o_resp_valid  output  1  one-cycle response pulse
o_resp_hit  output  1  qualifies o_resp_valid; 1 = hit
o_rdata  output  WORD_W  read data (write data for writes); valid with o_resp_valid
o_mem_req_valid  output  1  memory request pending
o_mem_we  output  1  1 = writeback, 0 = refill
o_mem_addr  output  ADDR_W  line-aligned word address (offset bits zero)
o_memory_line_out  output  WORD_W*LINE_WORDS  writeback line; word 0 in the LSBs
i_memory_line_in  input  WORD_W*LINE_WORDS  refill line; word 0 in the LSBs
i_memory_response_in  input  1  memory ack; completes the current memory request

Behaviour:
- Address split: offset = i_addr[OB-1:0], where OB = log2(LINE_WORDS). Index = the next log2(SETS) bits. Tag = the remaining upper bits.
- Per-line state: valid, dirty, tag, data. Per-set state: one log2(WAYS)-bit age per way.
- Reset: all valid and dirty bits = 0. Age of way i = i. All outputs = 0 except o_req_ready = 1. The state machine goes to IDLE.
- Reset mid-operation: any request or memory transaction in flight is abandoned. o_mem_req_valid = 0 from the cycle after the reset edge. No array update occurs.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: o_req_ready = 1. On valid & ready, latch we/addr/wdata and go to LOOKUP. o_req_ready = 0 in every other state; requests there are not accepted.
- LOOKUP, hit (valid & tag match):
  - Read: o_rdata = addressed word. Write: merge the word and set dirty.
  - Update LRU, then go to RESPOND.
  - Hit latency: o_resp_valid is high 2 cycles after the acceptance edge.
- LOOKUP, miss: victim = lowest-indexed invalid way, otherwise the way with age WAYS-1.
  - Victim valid & dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK:
  - o_mem_req_valid = 1, o_mem_we = 1, o_mem_addr = {victim tag, index, 0}, o_memory_line_out = victim data.
  - Outputs stay stable until i_memory_response_in; then go to REFILL.
- REFILL:
  - o_mem_req_valid = 1, o_mem_we = 0, o_mem_addr = {req tag, index, 0}.
  - On ack: write i_memory_line_in into the victim way. Set tag, valid = 1, dirty = we.
  - For a write, i_wdata replaces the addressed word in the same write.
  - Update LRU, then go to RESPOND.
  - o_mem_req_valid drops the cycle after the ack.
- RESPOND: o_resp_valid = 1 for exactly one cycle. o_resp_hit = 1 if the path was a hit, 0 if a miss. Then go to IDLE.
- o_rdata holds its last value outside responses.
- LRU update when way w (old age a) is accessed: age[w] = 0, and every way with age < a increments. Ages in a set always form a permutation of 0..WAYS-1.
- i_memory_response_in outside WRITEBACK/REFILL is ignored. An ack arriving in the same cycle the request is first asserted is legal and completes it.
- Memory-side back-pressure is unbounded; the FSM waits indefinitely.

Test Plan:
Defaults, word addresses: index = addr[5:2], tag = addr[31:6].
1. Cold read 0x41 -> REFILL with o_mem_addr 0x40, o_mem_we 0. Ack with line words {0xA,0xB,0xC,0xD} -> resp rdata 0xB, hit 0. Read 0x43 -> rdata 0xD, hit 1, response 2 cycles after accept, no memory request.
2. Write hit 0x42 data 0xDEADBEEF -> resp hit 1, no memory traffic. Read 0x42 -> 0xDEADBEEF.
3. LRU: read 0x000, 0x040, 0x080, 0x0C0 (all index 0, four refills), re-read 0x000, read 0x100 -> refill of 0x100 replaces the 0x040 line. Read 0x040 -> miss; read 0x000 -> hit.
4. Dirty eviction: write 0x001 = 0x1234 and make that line LRU. Read 0x100 -> WRITEBACK first with o_mem_addr 0x000, line word1 = 0x1234. Only after its ack is there a REFILL at 0x100.
5. Memory stall: withhold ack 10 cycles -> o_mem_req_valid/addr/we stable all 10 cycles. o_req_ready = 0 and i_req_valid pulses are not accepted. Ack on cycle 11 -> one response.
6. Reset in REFILL: assert rst one cycle -> o_mem_req_valid 0 and o_req_ready 1 next cycle. A following read of a previously-hit address -> miss (hit 0).

Source files
------------

// File: rtl/nway_sa_cache.sv
// N-way set-associative write-back / write-allocate cache with true-LRU replacement.
// A single request is handled at a time; misses go through an optional writeback and then a refill.
module nway_sa_cache #(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  input  logic                         i_req_we,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [WORD_W-1:0]            i_wdata,
  output logic                         o_req_ready,
  output logic                         o_resp_valid,
  output logic                         o_resp_hit,
  output logic [WORD_W-1:0]            o_rdata,
  output logic                         o_mem_req_valid,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [WORD_W*LINE_WORDS-1:0] o_memory_line_out,
  input  logic [WORD_W*LINE_WORDS-1:0] i_memory_line_in,
  input  logic                         i_memory_response_in
);

  localparam int OB     = $clog2(LINE_WORDS);
  localparam int IB     = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OB - IB;
  localparam int AGE_W  = $clog2(WAYS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [AGE_W-1:0]      victim_q, victim_d;
  logic                  hit_path_q, hit_path_d;
  logic [WORD_W-1:0]     rdata_q, rdata_d;

  logic                  valid_q [SETS][WAYS];
  logic                  dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]     data_q  [SETS][WAYS];
  logic [AGE_W-1:0]      age_q   [SETS][WAYS];

  logic [IB-1:0]         idx;
  logic [OB-1:0]         off;
  logic [TAG_W-1:0]      req_tag;

  logic                  hit, inv_found;
  logic [AGE_W-1:0]      hit_way, inv_way, lru_way, victim_sel;

  logic                  arr_we;
  logic [AGE_W-1:0]      arr_way;
  logic [LINE_W-1:0]     arr_line;
  logic                  arr_dirty;

  assign off     = addr_q[OB-1:0];
  assign idx     = addr_q[OB +: IB];
  assign req_tag = addr_q[ADDR_W-1 -: TAG_W];

  // Tag compare, first free way and oldest way of the addressed set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == req_tag) && !hit) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    victim_sel = inv_found ? inv_way : lru_way;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    hit_path_d = hit_path_q;
    rdata_d    = rdata_q;
    arr_we     = 1'b0;
    arr_way    = hit_way;
    arr_line   = data_q[idx][hit_way];
    arr_dirty  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          arr_we     = 1'b1;
          hit_path_d = 1'b1;
          state_d    = RESPOND;
          if (we_q) begin
            arr_line[off*WORD_W +: WORD_W] = wdata_q;
            arr_dirty = 1'b1;
            rdata_d   = wdata_q;
          end else begin
            arr_dirty = dirty_q[idx][hit_way];
            rdata_d   = arr_line[off*WORD_W +: WORD_W];
          end
        end else begin
          hit_path_d = 1'b0;
          victim_d   = victim_sel;
          // An invalid victim is never dirty, so only a full set can need a writeback.
          state_d    = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        if (i_memory_response_in) state_d = REFILL;
      end
      REFILL: begin
        if (i_memory_response_in) begin
          arr_we    = 1'b1;
          arr_way   = victim_q;
          arr_line  = i_memory_line_in;
          arr_dirty = we_q;
          if (we_q) begin
            arr_line[off*WORD_W +: WORD_W] = wdata_q;
            rdata_d = wdata_q;
          end else begin
            rdata_d = i_memory_line_in[off*WORD_W +: WORD_W];
          end
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hit_path_q <= 1'b0;
      rdata_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      state_q    <= state_d;
      hit_path_q <= hit_path_d;
      rdata_q    <= rdata_d;
      if (arr_we) begin
        valid_q[idx][arr_way] <= 1'b1;
        dirty_q[idx][arr_way] <= arr_dirty;
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == arr_way)
            age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][arr_way])
            age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    we_q     <= we_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    victim_q <= victim_d;
    if (!rst && arr_we) begin
      data_q[idx][arr_way] <= arr_line;
      tag_q[idx][arr_way]  <= req_tag;
    end
  end

  assign o_req_ready       = (state_q == IDLE);
  assign o_resp_valid      = (state_q == RESPOND);
  assign o_resp_hit        = (state_q == RESPOND) && hit_path_q;
  assign o_rdata           = rdata_q;
  assign o_mem_req_valid   = (state_q == WRITEBACK) || (state_q == REFILL);
  assign o_mem_we          = (state_q == WRITEBACK);
  assign o_mem_addr        = (state_q == WRITEBACK) ? {tag_q[idx][victim_q], idx, {OB{1'b0}}} :
                             (state_q == REFILL)    ? {req_tag, idx, {OB{1'b0}}} : '0;
  assign o_memory_line_out = (state_q == WRITEBACK) ? data_q[idx][victim_q] : '0;

endmodule
